// File: rtl/seq_play_ctrl.sv
// rtl/seq_play_ctrl.sv - plays a stored colour sequence on one-hot LEDs (FETCH/SHOW/GAP per step)
// Optional macro SEQ_SPEEDUP_EN: shortens the ON time as round_lat grows.
module seq_play_ctrl #(
  parameter int ON_CYCLES  = 50000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int ADDR_W     = 4
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   round,
  input  logic [1:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        leds,
  output logic              busy,
  output logic              end_FPGA
);
  localparam int MAX_DUR = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DUR + 1);
  localparam logic [ADDR_W:0]  MAX_ROUND = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE_IDX   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   idx, idx_next, round_lat, round_clamp;
  logic [CNT_W-1:0]  cnt, on_load;
  logic [3:0]        led_reg;

  assign round_clamp = (round > MAX_ROUND) ? MAX_ROUND : round;

  // Counters load duration-1 on entry and the state exits when they reach zero.
`ifdef SEQ_SPEEDUP_EN
  logic [CNT_W-1:0] on_shift;
  assign on_shift = CNT_W'(ON_CYCLES) >> round_lat[ADDR_W:ADDR_W-1];
  assign on_load  = (on_shift > CNT_W'(1)) ? on_shift - CNT_W'(1) : '0;
`else
  assign on_load  = CNT_W'(ON_CYCLES - 1);
`endif

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    leds       = 4'b0000;
    busy       = 1'b1;
    end_FPGA   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          idx_next   = '0;
          state_next = (round_clamp == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_next = SHOW;
      SHOW: begin
        leds = led_reg;
        if (cnt == '0) state_next = GAP;
      end
      GAP: begin
        if (cnt == '0) begin
          if (idx == round_lat - ONE_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + ONE_IDX;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        end_FPGA   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a pending step advance.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      idx_next   = idx;
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      round_lat <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      led_reg   <= 4'b0000;
    end else begin
      idx <= idx_next;
      if (state == IDLE && state_next != IDLE) round_lat <= round_clamp;
      if (state_next == FETCH && state != FETCH) mem_addr <= idx_next[ADDR_W-1:0];
      if (state == FETCH && state_next == SHOW) led_reg <= 4'b0001 << mem_data;
      if (state_next == SHOW && state != SHOW)      cnt <= on_load;
      else if (state_next == GAP && state != GAP)   cnt <= OFF_LOAD;
      else if (state_next != state)                 cnt <= '0;
      else if (cnt != '0)                           cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_seq_play_ctrl.sv
// tb/tb_seq_play_ctrl.sv - self-checking bench for seq_play_ctrl (ON=4, OFF=2, ADDR_W=4)
module tb_seq_play_ctrl;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int AW  = 4;

  logic          CLOCK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          glitch = 1'b0;
  logic [AW:0]   round = '0;
  logic [1:0]    mem_data;
  logic [AW-1:0] mem_addr;
  logic [3:0]    leds;
  logic          busy, end_FPGA;

  logic [1:0]    mem [16];
  int            checks = 0;
  int            errors = 0;
  int            end_pulses = 0;
  int            cyc, p;
  logic [3:0]    trace_leds [0:511];
  logic [AW-1:0] trace_addr [0:511];
  logic [15:0]   addr_seen;

  typedef struct packed {
    logic [3:0]    leds;
    logic          busy;
    logic          endp;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t q[$];
  exp_t exp_now = '0;

  seq_play_ctrl #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .ADDR_W(AW)) dut (
    .CLOCK(CLOCK), .reset(reset), .start(start), .abort(abort), .round(round),
    .mem_data(mem_data), .mem_addr(mem_addr), .leds(leds), .busy(busy), .end_FPGA(end_FPGA)
  );

  always #5 CLOCK = ~CLOCK;
  assign mem_data = mem[mem_addr] ^ {2{glitch}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle trace of one playback, appended to q.
  task automatic build(input int r);
    int n, on;
    exp_t e;
    n  = (r > 16) ? 16 : r;
    on = ON;
`ifdef SEQ_SPEEDUP_EN
    on = ON >> (n / 8);
    if (on < 1) on = 1;
`endif
    for (int i = 0; i < n; i++) begin
      e.addr = AW'(i); e.busy = 1'b1; e.endp = 1'b0; e.leds = 4'b0000;
      q.push_back(e);
      e.leds = 4'(1 << mem[i]);
      repeat (on) q.push_back(e);
      e.leds = 4'b0000;
      repeat (OFF) q.push_back(e);
    end
    e.leds = 4'b0000; e.busy = 1'b1; e.endp = 1'b1;
    e.addr = (n > 0) ? AW'(n - 1) : exp_now.addr;
    q.push_back(e);
  endtask

  always @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      q.delete();
      exp_now = '0;
    end else if (exp_now.busy && abort) begin
      q.delete();
      exp_now.busy = 1'b0; exp_now.leds = 4'b0000; exp_now.endp = 1'b0;
    end else begin
      if (!exp_now.busy && start && !abort) build(int'(round));
      if (q.size() > 0) exp_now = q.pop_front();
      else begin
        exp_now.busy = 1'b0; exp_now.leds = 4'b0000; exp_now.endp = 1'b0;
      end
    end
  end

  always @(negedge CLOCK) begin
    check("cycle", {22'd0, leds, busy, end_FPGA, mem_addr}, {22'd0, exp_now});
    if (end_FPGA === 1'b1) end_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Starts playback at a negedge; cycle k is the state after the k-th edge from start sampling.
  task automatic run(input int r, input bit do_glitch, output int c);
    addr_seen = '0;
    round = (AW+1)'(r);
    start = 1'b1;
    c = 0;
    while (c < 400) begin
      @(posedge CLOCK);
      c++;
      @(negedge CLOCK);
      start = 1'b0;
      trace_leds[c] = leds;
      trace_addr[c] = mem_addr;
      if (busy) addr_seen[mem_addr] = 1'b1;
      if (do_glitch && c == 2) glitch = 1'b1;
      if (do_glitch && c == 4) glitch = 1'b0;
      if (end_FPGA === 1'b1) break;
    end
    if (c >= 400) check("run_timeout", c, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'((i * 3 + 1) % 4);
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    reset = 1'b0;
    #1;
    check("rst_leds", leds, 0);
    check("rst_busy", busy, 0);
    check("rst_end", end_FPGA, 0);
    check("rst_addr", mem_addr, 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    run(3, 1'b1, cyc);
    check("r3_end_cycle", cyc, 22);
    check("r3_led_c2", trace_leds[2], 4'b0100);
    check("r3_led_c5", trace_leds[5], 4'b0100);
    check("r3_led_c6", trace_leds[6], 4'b0000);
    check("r3_led_c9", trace_leds[9], 4'b0001);
    check("r3_led_c16", trace_leds[16], 4'b1000);
    check("r3_led_c19", trace_leds[19], 4'b1000);
    check("r3_led_c20", trace_leds[20], 4'b0000);
    tick(3);

    run(0, 1'b0, cyc);
    check("r0_end_cycle", cyc, 1);
    check("r0_leds", trace_leds[1], 4'b0000);
    tick(3);

    run(20, 1'b0, cyc);
`ifdef SEQ_SPEEDUP_EN
    check("r20_end_cycle", cyc, 65);
`else
    check("r20_end_cycle", cyc, 113);
`endif
    check("r20_addr_seen", addr_seen, 16'hffff);
    tick(3);

    run(8, 1'b0, cyc);
`ifdef SEQ_SPEEDUP_EN
    check("r8_end_cycle", cyc, 41);
`else
    check("r8_end_cycle", cyc, 57);
`endif
    tick(3);

    round = 5'd3; start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    round = 5'd1; start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    check("abort_pre_leds", leds, 4'b0001);
    p = end_pulses;
    abort = 1'b1; tick(1); abort = 1'b0;
    check("abort_leds", leds, 0);
    check("abort_busy", busy, 0);
    tick(30);
    check("abort_no_end", end_pulses - p, 0);

    round = 5'd3; start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);
    tick(3);

    round = 5'd3; start = 1'b1; tick(1); start = 1'b0;
    tick(12);
    check("gap_addr_pre", mem_addr, 1);
    #2;
    p = end_pulses;
    reset = 1'b0;
    #1;
    check("mid_rst_leds", leds, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_end", end_FPGA, 0);
    check("mid_rst_addr", mem_addr, 0);
    tick(2);
    reset = 1'b1;
    tick(20);
    check("mid_rst_no_end", end_pulses - p, 0);
    check("mid_rst_idle", busy, 0);

    run(2, 1'b0, cyc);
    check("replay_end_cycle", cyc, 15);
    check("replay_addr_c1", trace_addr[1], 0);
    check("replay_led_c2", trace_leds[2], 4'b0100);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
